delay_align: RTL and testbench

//  Receive-side counterpart of the fixed-latency delay stage. Two valid-qualified lanes arrive with an

---
 rtl/delay_align.sv | 135 +++++++++++++
 tb/tb_delay_align.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_align.sv
// rtl/delay_align.sv - aligns an early lane to a skewed late lane via a small FIFO
//
// Purpose: the early lane is buffered in a DEPTH-entry FIFO; each late-lane beat
// pops the head and both words leave together as one registered aligned pair.
// Optional macro DELAY_ALIGN_ERRCNT_EN enables the saturating error counter.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   clear           synchronous flush, same effect as reset
//   in_e_vld/data   early lane (no backpressure)
//   in_l_vld/data   late lane (no backpressure)
//   out_vld         aligned pair valid (registered)
//   out_e_data      early word of the pair
//   out_l_data      late word of the pair
//   level           early words currently buffered
//   err_ovf         1-cycle pulse, early word dropped on full FIFO
//   err_unf         1-cycle pulse, late word dropped with no early word available
//   err_cnt         saturating error count (0 when DELAY_ALIGN_ERRCNT_EN undefined)

module delay_align #(
    parameter int E_WIDTH = 8,
    parameter int L_WIDTH = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_e_vld,
    input  logic [E_WIDTH-1:0]         in_e_data,
    input  logic                       in_l_vld,
    input  logic [L_WIDTH-1:0]         in_l_data,
    output logic                       out_vld,
    output logic [E_WIDTH-1:0]         out_e_data,
    output logic [L_WIDTH-1:0]         out_l_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_ovf,
    output logic                       err_unf,
    output logic [15:0]                err_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [E_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;

    logic flush;
    logic empty;
    logic full;
    logic pop;
    logic bypass;
    logic push;
    logic ovf;
    logic unf;
    logic [E_WIDTH-1:0] head;

    assign flush = reset | clear;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_comb begin
        pop    = in_l_vld && !empty;
        // Zero skew: pair the words directly and leave the FIFO untouched.
        bypass = in_l_vld && empty && in_e_vld;
        // On full, a simultaneous pop frees the head slot, so the push may
        // reuse it: the read sees the old word, the write lands at the edge.
        push   = in_e_vld && !bypass && (!full || pop);
        ovf    = in_e_vld && full && !pop;
        unf    = in_l_vld && empty && !in_e_vld;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_e_data;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_vld    <= 1'b0;
            out_e_data <= '0;
            out_l_data <= '0;
            err_ovf    <= 1'b0;
            err_unf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            out_vld <= pop | bypass;
            if (pop) begin
                out_e_data <= head;
                out_l_data <= in_l_data;
            end else if (bypass) begin
                out_e_data <= in_e_data;
                out_l_data <= in_l_data;
            end
            err_ovf <= ovf;
            err_unf <= unf;
        end
    end

`ifdef DELAY_ALIGN_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic [16:0] cnt_sum;

    // Counter moves on the same edge that raises the pulse it counts.
    always_comb begin
        cnt_sum = {1'b0, err_cnt_q} + {16'b0, ovf} + {16'b0, unf};
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            err_cnt_q <= '0;
        end else if (cnt_sum[16]) begin
            err_cnt_q <= 16'hFFFF;
        end else begin
            err_cnt_q <= cnt_sum[15:0];
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_delay_align.sv
// tb/tb_delay_align.sv - directed self-checking bench for delay_align
module tb_delay_align;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_e_vld;
    logic [7:0] in_e_data;
    logic       in_l_vld;
    logic [7:0] in_l_data;
    logic       out_vld;
    logic [7:0] out_e_data;
    logic [7:0] out_l_data;
    logic [2:0] level;
    logic       err_ovf;
    logic       err_unf;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DELAY_ALIGN_ERRCNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    delay_align #(.E_WIDTH(8), .L_WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_e_vld   (in_e_vld),
        .in_e_data  (in_e_data),
        .in_l_vld   (in_l_vld),
        .in_l_data  (in_l_data),
        .out_vld    (out_vld),
        .out_e_data (out_e_data),
        .out_l_data (out_l_data),
        .level      (level),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [7:0] ed, input logic lv, input logic [7:0] ld);
        in_e_vld  = ev;
        in_e_data = ed;
        in_l_vld  = lv;
        in_l_data = ld;
    endtask

    task automatic do_reset;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        #1;

        // Reset state
        do_reset();
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_e", 32'(out_e_data), 32'd0);
        chk("rst_l", 32'(out_l_data), 32'd0);
        chk("rst_ovf", 32'(err_ovf), 32'd0);
        chk("rst_unf", 32'(err_unf), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);

        // 1: skew 0, bypass pairs
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h11 + i), 1'b1, 8'(8'hA1 + i));
            tick();
            chk("s0_vld", 32'(out_vld), 32'd1);
            chk("s0_e", 32'(out_e_data), 32'(8'h11 + i));
            chk("s0_l", 32'(out_l_data), 32'(8'hA1 + i));
            chk("s0_level", 32'(level), 32'd0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        chk("s0_idle_vld", 32'(out_vld), 32'd0);
        chk("s0_hold_e", 32'(out_e_data), 32'h14);
        chk("s0_hold_l", 32'(out_l_data), 32'hA4);

        // 2: skew 3, 8 beats
        for (int t = 0; t < 11; t++) begin
            int pushes;
            int pops;
            drive(t < 8, 8'(8'h20 + t), (t >= 3), 8'(8'hB0 + t - 3));
            tick();
            pushes = (t + 1 < 8) ? t + 1 : 8;
            pops   = (t >= 3) ? t - 2 : 0;
            chk("s3_level", 32'(level), 32'(pushes - pops));
            chk("s3_vld", 32'(out_vld), 32'(t >= 3));
            if (t >= 3) begin
                chk("s3_e", 32'(out_e_data), 32'(8'h20 + t - 3));
                chk("s3_l", 32'(out_l_data), 32'(8'hB0 + t - 3));
            end
            chk("s3_ovf", 32'(err_ovf), 32'd0);
            chk("s3_unf", 32'(err_unf), 32'd0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();

        // 3: overflow
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h31 + i), 1'b0, 8'h00);
            tick();
            chk("ovf_level", 32'(level), 32'((i < 4) ? i + 1 : 4));
            chk("ovf_pulse", 32'(err_ovf), 32'(i == 4));
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        chk("ovf_pulse_end", 32'(err_ovf), 32'd0);
        chk("ovf_cnt", 32'(err_cnt), 32'(CNT_ON));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(8'hC1 + i));
            tick();
            chk("ovf_drain_vld", 32'(out_vld), 32'd1);
            chk("ovf_drain_e", 32'(out_e_data), 32'(8'h31 + i));
            chk("ovf_drain_l", 32'(out_l_data), 32'(8'hC1 + i));
            chk("ovf_drain_level", 32'(level), 32'(3 - i));
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        chk("ovf_after_vld", 32'(out_vld), 32'd0);
        chk("ovf_after_unf", 32'(err_unf), 32'd0);

        // 4: underflow from a clean state
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'hDD);
        tick();
        chk("unf_vld", 32'(out_vld), 32'd0);
        chk("unf_pulse", 32'(err_unf), 32'd1);
        chk("unf_cnt", 32'(err_cnt), 32'(CNT_ON));
        chk("unf_l_not_taken", 32'(out_l_data), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        chk("unf_pulse_end", 32'(err_unf), 32'd0);
        chk("unf_level", 32'(level), 32'd0);

        // 5: full + push + pop across pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h41 + i), 1'b0, 8'h00);
            tick();
        end
        chk("full_level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h45 + i), 1'b1, 8'(8'hE1 + i));
            tick();
            chk("pp_vld", 32'(out_vld), 32'd1);
            chk("pp_e", 32'(out_e_data), 32'(8'h41 + i));
            chk("pp_l", 32'(out_l_data), 32'(8'hE1 + i));
            chk("pp_level", 32'(level), 32'd4);
            chk("pp_ovf", 32'(err_ovf), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(8'hF1 + i));
            tick();
            chk("pp_drain_e", 32'(out_e_data), 32'(8'h45 + i));
            chk("pp_drain_l", 32'(out_l_data), 32'(8'hF1 + i));
            chk("pp_drain_level", 32'(level), 32'(3 - i));
        end

        // 6a: clear mid-stream at level 2 (beats in the clear cycle discarded)
        drive(1'b1, 8'h51, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'h52, 1'b0, 8'h00);
        tick();
        chk("clr_pre_level", 32'(level), 32'd2);
        drive(1'b1, 8'h53, 1'b1, 8'h99);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_vld", 32'(out_vld), 32'd0);
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        chk("clr_e", 32'(out_e_data), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'h77);
        tick();
        chk("clr_unf", 32'(err_unf), 32'd1);
        chk("clr_unf_vld", 32'(out_vld), 32'd0);
        chk("clr_unf_cnt", 32'(err_cnt), 32'(CNT_ON));

        // 6b: reset mid-stream at level 2
        drive(1'b1, 8'h61, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'h62, 1'b0, 8'h00);
        tick();
        chk("rst2_pre_level", 32'(level), 32'd2);
        drive(1'b1, 8'h63, 1'b1, 8'h88);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_vld", 32'(out_vld), 32'd0);
        chk("rst2_cnt", 32'(err_cnt), 32'd0);
        chk("rst2_ovf", 32'(err_ovf), 32'd0);
        chk("rst2_unf0", 32'(err_unf), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'h66);
        tick();
        chk("rst2_unf", 32'(err_unf), 32'd1);
        chk("rst2_unf_vld", 32'(out_vld), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
